// File: rtl/quar_pkg.sv
// Shared types and default constants for the quarantine sequencer.
package quar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        QUAR = 2'b01,
        LOCK = 2'b10
    } state_t;

    localparam logic [3:0]  DEF_PASSWORD   = 4'hA;
    localparam int unsigned DEF_QUAR_TICKS = 8;
    localparam int unsigned DEF_LOCK_TICKS = 5;
    localparam int unsigned DEF_MAX_FAIL   = 3;

endpackage

// File: rtl/quar_down_counter.sv
// Loadable down counter that saturates at zero; is_zero is registered
// alongside the count so it never lags the value it describes.
module quar_down_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             is_zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            is_zero <= 1'b1;
        end else if (load) begin
            count   <= load_val;
            is_zero <= (load_val == '0);
        end else if (en && !is_zero) begin
            count   <= count - 1'b1;
            is_zero <= (count == CNT_W'(1));
        end
    end

endmodule

// File: rtl/quar_sequencer.sv
// Quarantine/lockout sequencer for the password/LED subsystem.
// Optional QUAR_EXTEND_EN: pulseL during quarantine reloads the remaining time.
module quar_sequencer #(
    parameter int unsigned           PW_W       = 4,
    parameter logic [PW_W-1:0]       PASSWORD   = PW_W'(quar_pkg::DEF_PASSWORD),
    parameter int unsigned           QUAR_TICKS = quar_pkg::DEF_QUAR_TICKS,
    parameter int unsigned           LOCK_TICKS = quar_pkg::DEF_LOCK_TICKS,
    parameter int unsigned           MAX_FAIL   = quar_pkg::DEF_MAX_FAIL,
    parameter int unsigned           CNT_W      = 16
) (
    input  logic                           slowclock,
    input  logic                           reset,
    input  logic                           pulseC,
    input  logic                           pulseR,
    input  logic                           pulseL,
    input  logic [PW_W-1:0]                password,
    output logic                           QUAR,
    output logic                           quar_start,
    output logic                           lockout,
    output logic [$clog2(MAX_FAIL+1)-1:0]  fail_cnt,
    output logic [CNT_W-1:0]               remaining,
    output logic                           outputFlag
);

    import quar_pkg::*;

    localparam int unsigned FAIL_W  = $clog2(MAX_FAIL + 1);
    localparam int unsigned FAILX_W = FAIL_W + 1;

    // The QUAR port shadows the enum member, so states are always package-qualified.
    state_t           state;
    logic             pw_ok;
    logic             release_hit;
    logic             lock_hit;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_en;
    logic             cnt_zero;

    assign pw_ok       = (password == PASSWORD);
    assign release_hit = pulseR && pw_ok;
    assign lock_hit    = (FAILX_W'(fail_cnt) + FAILX_W'(1)) >= FAILX_W'(MAX_FAIL);

`ifdef QUAR_EXTEND_EN
    logic extend_hit;
    assign extend_hit = pulseL && !release_hit;
`else
    logic extend_unused;
    assign extend_unused = pulseL;
`endif

    // Counter control: shared by quarantine and lockout timing.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;
        case (state)
            quar_pkg::IDLE: begin
                if (pulseC && pw_ok) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(QUAR_TICKS - 1);
                end else if (pulseC && lock_hit) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(LOCK_TICKS - 1);
                end
            end
            quar_pkg::QUAR: begin
                if (release_hit) begin
                    cnt_load = 1'b1;
`ifdef QUAR_EXTEND_EN
                end else if (extend_hit) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(QUAR_TICKS - 1);
`endif
                end else begin
                    cnt_en = 1'b1;
                end
            end
            quar_pkg::LOCK: cnt_en = 1'b1;
            default: cnt_load = 1'b1;
        endcase
    end

    quar_down_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk     (slowclock),
        .rst     (reset),
        .load    (cnt_load),
        .load_val(cnt_load_val),
        .en      (cnt_en),
        .count   (remaining),
        .is_zero (cnt_zero)
    );

    always_ff @(posedge slowclock) begin
        if (reset) begin
            state      <= quar_pkg::IDLE;
            QUAR       <= 1'b0;
            quar_start <= 1'b0;
            lockout    <= 1'b0;
            fail_cnt   <= '0;
            outputFlag <= 1'b1;
        end else begin
            quar_start <= 1'b0;
            case (state)
                quar_pkg::IDLE: begin
                    if (pulseC) begin
                        outputFlag <= 1'b0;
                        if (pw_ok) begin
                            state      <= quar_pkg::QUAR;
                            QUAR       <= 1'b1;
                            quar_start <= 1'b1;
                            fail_cnt   <= '0;
                        end else if (lock_hit) begin
                            state    <= quar_pkg::LOCK;
                            lockout  <= 1'b1;
                            fail_cnt <= FAIL_W'(MAX_FAIL);
                        end else begin
                            fail_cnt <= fail_cnt + FAIL_W'(1);
                        end
                    end
                end
                quar_pkg::QUAR: begin
                    if (release_hit) begin
                        state <= quar_pkg::IDLE;
                        QUAR  <= 1'b0;
`ifdef QUAR_EXTEND_EN
                    end else if (extend_hit) begin
                        state <= quar_pkg::QUAR;
`endif
                    end else if (cnt_zero) begin
                        state <= quar_pkg::IDLE;
                        QUAR  <= 1'b0;
                    end
                end
                quar_pkg::LOCK: begin
                    if (cnt_zero) begin
                        state    <= quar_pkg::IDLE;
                        lockout  <= 1'b0;
                        fail_cnt <= '0;
                    end
                end
                default: begin
                    state   <= quar_pkg::IDLE;
                    QUAR    <= 1'b0;
                    lockout <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quar_sequencer.sv
// Directed bench for quar_sequencer with PASSWORD=A, QUAR 8, LOCK 5, MAX_FAIL 3.
module tb_quar_sequencer;

    logic        slowclock = 1'b0;
    logic        reset     = 1'b1;
    logic        pulseC    = 1'b0;
    logic        pulseR    = 1'b0;
    logic        pulseL    = 1'b0;
    logic [3:0]  password  = 4'h0;
    logic        QUAR;
    logic        quar_start;
    logic        lockout;
    logic [1:0]  fail_cnt;
    logic [15:0] remaining;
    logic        outputFlag;

    int n_cmp  = 0;
    int n_fail = 0;

    // {QUAR, quar_start, lockout, fail_cnt, remaining, outputFlag}
    logic [21:0] obs;
    logic [21:0] exp_v;
    assign obs = {QUAR, quar_start, lockout, fail_cnt, remaining, outputFlag};

    quar_sequencer dut (
        .slowclock (slowclock),
        .reset     (reset),
        .pulseC    (pulseC),
        .pulseR    (pulseR),
        .pulseL    (pulseL),
        .password  (password),
        .QUAR      (QUAR),
        .quar_start(quar_start),
        .lockout   (lockout),
        .fail_cnt  (fail_cnt),
        .remaining (remaining),
        .outputFlag(outputFlag)
    );

    always #5 slowclock = ~slowclock;

    function automatic logic [21:0] pk(input logic q, input logic s, input logic l,
                                       input logic [1:0] f, input logic [15:0] r,
                                       input logic o);
        return {q, s, l, f, r, o};
    endfunction

    task automatic tick();
        @(posedge slowclock);
        #1;
    endtask

    task automatic press(input logic c, input logic r, input logic l, input logic [3:0] pw);
        pulseC = c; pulseR = r; pulseL = l; password = pw;
        tick();
        pulseC = 1'b0; pulseR = 1'b0; pulseL = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        exp_v = pk(0, 0, 0, 2'd0, 16'd0, 1);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_quar();
        press(1, 0, 0, 4'hA);
        exp_v = pk(1, 1, 0, 2'd0, 16'd7, 0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL quar_entry: got %h expected %h", obs, exp_v);
        end
        for (int i = 1; i < 8; i++) begin
            tick();
            exp_v = pk(1, 0, 0, 2'd0, 16'(7 - i), 0);
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL quar_count[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
        tick();
        exp_v = pk(0, 0, 0, 2'd0, 16'd0, 0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL quar_expiry: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_lockout();
        press(1, 0, 0, 4'h3);
        exp_v = pk(0, 0, 0, 2'd1, 16'd0, 0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL wrong_1: got %h expected %h", obs, exp_v);
        end
        press(1, 0, 0, 4'h3);
        exp_v = pk(0, 0, 0, 2'd2, 16'd0, 0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL wrong_2: got %h expected %h", obs, exp_v);
        end
        press(1, 0, 0, 4'h3);
        exp_v = pk(0, 0, 1, 2'd3, 16'd4, 0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL lock_entry: got %h expected %h", obs, exp_v);
        end
        // Correct code during lockout must not start quarantine.
        press(1, 0, 0, 4'hA);
        exp_v = pk(0, 0, 1, 2'd3, 16'd3, 0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL lock_ignore: got %h expected %h", obs, exp_v);
        end
        for (int i = 2; i >= 0; i--) begin
            tick();
            exp_v = pk(0, 0, 1, 2'd3, 16'(i), 0);
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL lock_count[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
        tick();
        exp_v = pk(0, 0, 0, 2'd0, 16'd0, 0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL lock_expiry: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_release();
        press(1, 0, 0, 4'hA);
        tick(); tick(); tick();
        press(0, 1, 0, 4'hA);
        exp_v = pk(0, 0, 0, 2'd0, 16'd0, 0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL release_ok: got %h expected %h", obs, exp_v);
        end
        press(1, 0, 0, 4'hA);
        tick(); tick(); tick();
        press(0, 1, 0, 4'h5);
        exp_v = pk(1, 0, 0, 2'd0, 16'd3, 0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL release_bad: got %h expected %h", obs, exp_v);
        end
        tick(); tick(); tick();
        exp_v = pk(1, 0, 0, 2'd0, 16'd0, 0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL release_bad_last: got %h expected %h", obs, exp_v);
        end
        tick();
        exp_v = pk(0, 0, 0, 2'd0, 16'd0, 0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL release_bad_end: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_reset_mid();
        press(1, 0, 0, 4'hA);
        tick(); tick(); tick(); tick();
        exp_v = pk(1, 0, 0, 2'd0, 16'd3, 0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL mid_pre: got %h expected %h", obs, exp_v);
        end
        reset = 1'b1;
        press(0, 1, 1, 4'hA);
        reset = 1'b0;
        exp_v = pk(0, 0, 0, 2'd0, 16'd0, 1);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL mid_reset: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_simultaneous();
        press(1, 1, 0, 4'hA);
        exp_v = pk(1, 1, 0, 2'd0, 16'd7, 0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL simul_entry: got %h expected %h", obs, exp_v);
        end
        repeat (8) tick();
        press(1, 0, 0, 4'h3);
        press(1, 0, 0, 4'h7);
        exp_v = pk(0, 0, 0, 2'd2, 16'd0, 0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL simul_two_wrong: got %h expected %h", obs, exp_v);
        end
        press(1, 0, 0, 4'hA);
        exp_v = pk(1, 1, 0, 2'd0, 16'd7, 0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL simul_clear: got %h expected %h", obs, exp_v);
        end
        repeat (8) tick();
        exp_v = pk(0, 0, 0, 2'd0, 16'd0, 0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL simul_end: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_extend();
        int more;
        press(1, 0, 0, 4'hA);
        repeat (5) tick();
        press(0, 0, 1, 4'h0);
`ifdef QUAR_EXTEND_EN
        exp_v = pk(1, 0, 0, 2'd0, 16'd7, 0);
        more  = 7;
`else
        exp_v = pk(1, 0, 0, 2'd0, 16'd1, 0);
        more  = 1;
`endif
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL extend_press: got %h expected %h", obs, exp_v);
        end
        repeat (more) tick();
        exp_v = pk(1, 0, 0, 2'd0, 16'd0, 0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL extend_last: got %h expected %h", obs, exp_v);
        end
        tick();
        exp_v = pk(0, 0, 0, 2'd0, 16'd0, 0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL extend_end: got %h expected %h", obs, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_quar();
        test_lockout();
        test_release();
        test_reset_mid();
        test_simultaneous();
        test_extend();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
